mseq_rx: RTL and testbench

Serial receiver and synchroniser for the 4-bit maximal-length (M-sequence) bit stream produced by the team's M-function generator. It reconstructs the generator's LFSR phase from incoming bits, locks onto the sequence, then flywheels a local replica to flag and correct bit errors. The block sits at the far end of the serial link, one bit per `in_valid` strobe, and feeds lock status, a period marker and error statistics to downstream logic.

---
 rtl/mseq_pkg.sv | 8 +
 rtl/mseq_lfsr_step.sv | 13 +
 rtl/mseq_rx.sv | 125 ++++++++++++
 tb/tb_mseq_rx.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mseq_pkg.sv
// mseq_pkg: shared M-sequence types, width and LFSR prediction for generator and receiver.
package mseq_pkg;
  localparam int MSEQ_W = 4;
  typedef enum logic [1:0] {ACQ, VERIFY, LOCK} state_t;
  function automatic logic lfsr_pred(input logic [MSEQ_W-1:0] window, input logic [MSEQ_W-1:0] taps);
    return ^(window & taps);
  endfunction
endpackage

// File: rtl/mseq_lfsr_step.sv
// mseq_lfsr_step: one combinational LFSR step.
// st: current window/replica, taps: feedback mask, pred: next sequence bit, nxt: state after shifting pred in at the MSB.
module mseq_lfsr_step
  import mseq_pkg::*;
(
  input  logic [MSEQ_W-1:0] st,
  input  logic [MSEQ_W-1:0] taps,
  output logic              pred,
  output logic [MSEQ_W-1:0] nxt
);
  assign pred = lfsr_pred(st, taps);
  assign nxt  = {pred, st[MSEQ_W-1:1]};
endmodule

// File: rtl/mseq_rx.sv
// mseq_rx: M-sequence receiver that acquires LFSR phase, locks, and flywheels a replica to flag/correct bit errors.
// Ports: CLK_50MHZ clock, RST sync active-high reset, in_fun/in_valid serial input with strobe;
// locked, bit_out/bit_out_valid corrected bit, rx_err mismatch pulse, sync period pulse, phase window/replica, err_cnt error count.
// MSEQ_RX_ERRCNT_EN: when defined, err_cnt is a 16-bit saturating counter; otherwise tied to zero.
module mseq_rx
  import mseq_pkg::*;
#(
  parameter logic [MSEQ_W-1:0] TYPE_PARAM = 4'b1001,
  parameter logic [MSEQ_W-1:0] SYNC_PARAM = 4'b0101,
  parameter int                LOCK_CNT   = 8,
  parameter int                MISS_LIMIT = 3
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              in_fun,
  input  logic              in_valid,
  output logic              locked,
  output logic              bit_out,
  output logic              bit_out_valid,
  output logic              rx_err,
  output logic              sync,
  output logic [MSEQ_W-1:0] phase,
  output logic [15:0]       err_cnt
);
  localparam int VW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  state_t            state, state_n;
  logic [MSEQ_W-1:0] window, window_n, replica, replica_n, step_in, step_nxt;
  logic [1:0]        fill_cnt, fill_n;
  logic [VW-1:0]     ver_cnt, ver_n;
  logic [MW-1:0]     miss_cnt, miss_n;
  logic              pred, match, bo_n, bov_n, err_n, sync_n;
  assign step_in = (state == LOCK) ? replica : window;
  mseq_lfsr_step u_step (
    .st   (step_in),
    .taps (TYPE_PARAM),
    .pred (pred),
    .nxt  (step_nxt)
  );
  // An all-zero window is the LFSR lock-up state and can never predict correctly.
  assign match = (pred == in_fun) && (|window);
  always_comb begin
    state_n   = state;
    window_n  = window;
    replica_n = replica;
    fill_n    = fill_cnt;
    ver_n     = ver_cnt;
    miss_n    = miss_cnt;
    bo_n      = bit_out;
    bov_n     = 1'b0;
    err_n     = 1'b0;
    sync_n    = 1'b0;
    if (in_valid) begin
      window_n = {in_fun, window[MSEQ_W-1:1]};
      bov_n    = 1'b1;
      bo_n     = in_fun;
      case (state)
        ACQ: begin
          fill_n = fill_cnt + 2'd1;
          if (fill_cnt == 2'd3) begin
            state_n = VERIFY;
            ver_n   = '0;
          end
        end
        VERIFY: begin
          ver_n = match ? ver_cnt + 1'b1 : '0;
          if (match && ver_cnt == VW'(LOCK_CNT - 1)) begin
            state_n   = LOCK;
            replica_n = window_n;
            miss_n    = '0;
          end
        end
        LOCK: begin
          replica_n = step_nxt;
          bo_n      = pred;
          err_n     = pred != in_fun;
          miss_n    = err_n ? miss_cnt + 1'b1 : '0;
          if (err_n && miss_cnt == MW'(MISS_LIMIT - 1)) begin
            state_n = ACQ;
            fill_n  = '0;
          end
        end
        default: state_n = ACQ;
      endcase
      sync_n = (state_n == LOCK) && (replica_n == SYNC_PARAM);
    end
  end
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state         <= ACQ;
      window        <= '0;
      replica       <= '0;
      fill_cnt      <= '0;
      ver_cnt       <= '0;
      miss_cnt      <= '0;
      bit_out       <= 1'b0;
      bit_out_valid <= 1'b0;
      rx_err        <= 1'b0;
      sync          <= 1'b0;
    end else begin
      state         <= state_n;
      window        <= window_n;
      replica       <= replica_n;
      fill_cnt      <= fill_n;
      ver_cnt       <= ver_n;
      miss_cnt      <= miss_n;
      bit_out       <= bo_n;
      bit_out_valid <= bov_n;
      rx_err        <= err_n;
      sync          <= sync_n;
    end
  end
  assign locked = state == LOCK;
  assign phase  = locked ? replica : window;
`ifdef MSEQ_RX_ERRCNT_EN
  logic [15:0] err_q;
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) err_q <= '0;
    else if (err_n && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
  end
  assign err_cnt = err_q;
`else
  assign err_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_mseq_rx.sv
// tb_mseq_rx: randomized self-checking bench for mseq_rx against a sequence-table reference model.
module tb_mseq_rx;
  logic        CLK_50MHZ = 0, RST = 1, in_fun = 0, in_valid = 0;
  logic        locked, bit_out, bit_out_valid, rx_err, sync;
  logic [3:0]  phase;
  logic [15:0] err_cnt;
  mseq_rx dut (
    .CLK_50MHZ     (CLK_50MHZ),
    .RST           (RST),
    .in_fun        (in_fun),
    .in_valid      (in_valid),
    .locked        (locked),
    .bit_out       (bit_out),
    .bit_out_valid (bit_out_valid),
    .rx_err        (rx_err),
    .sync          (sync),
    .phase         (phase),
    .err_cnt       (err_cnt)
  );
  always #10 CLK_50MHZ = ~CLK_50MHZ;
  int n_chk = 0, n_err = 0;
  bit seq [15] = '{1,0,0,0,1,1,1,1,0,1,0,1,1,0,0};
  int m_st, fill, run, miss, lp, e_err, sp, flips, acc, lock_at;
  bit zmode, armed;
  logic [3:0] win, e_phase;
  logic e_locked, e_bo, e_bov, e_rx, e_sync;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // Position of a 4-bit window in the reference period, -1 if it never occurs.
  function automatic int find(input logic [3:0] w);
    for (int p = 0; p < 15; p++) begin
      bit ok = 1;
      for (int i = 0; i < 4; i++) if (seq[(p + i) % 15] != w[i]) ok = 0;
      if (ok) return p;
    end
    return -1;
  endfunction
  function automatic logic [3:0] pack(input int p);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = seq[(p + i) % 15];
    return r;
  endfunction
  task automatic model(input bit r, input bit v, input bit b);
    int p;
    bit pr;
    e_bov = 0; e_rx = 0; e_sync = 0;
    if (r) begin
      m_st = 0; fill = 0; run = 0; miss = 0; win = 0; e_err = 0; e_bo = 0;
      acc = 0; lock_at = -1; e_locked = 0; e_phase = 0;
      return;
    end
    if (!v) return;
    acc++;
    e_bov = 1;
    e_bo = b;
    p = find(win);
    if (m_st == 0) begin
      fill++;
      if (fill == 4) begin m_st = 1; run = 0; end
    end else if (m_st == 1) begin
      if (p >= 0 && seq[(p + 4) % 15] == b) begin
        run++;
        if (run == 8) begin m_st = 2; lp = (p + 1) % 15; miss = 0; lock_at = acc; end
      end else run = 0;
    end else begin
      pr = seq[(lp + 4) % 15];
      e_bo = pr;
      lp = (lp + 1) % 15;
      if (pr != b) begin
        e_rx = 1;
        if (e_err < 65535) e_err++;
        miss++;
        if (miss == 3) begin m_st = 0; fill = 0; end
      end else miss = 0;
    end
    win = {b, win[3:1]};
    e_locked = m_st == 2;
    e_phase = e_locked ? pack(lp) : win;
    e_sync = e_locked && e_phase == 4'b0101;
  endtask
  task automatic check_all();
    check("locked", locked, e_locked);
    check("bit_out", bit_out, e_bo);
    check("bit_out_valid", bit_out_valid, e_bov);
    check("rx_err", rx_err, e_rx);
    check("sync", sync, e_sync);
    check("phase", phase, e_phase);
`ifdef MSEQ_RX_ERRCNT_EN
    check("err_cnt", err_cnt, e_err);
`else
    check("err_cnt", err_cnt, 0);
`endif
  endtask
  task automatic cyc(input bit r, input bit v);
    bit b;
    @(negedge CLK_50MHZ);
    if (armed) check_all();
    b = zmode ? 1'b0 : (v ? seq[sp] ^ (flips > 0) : 1'($urandom_range(0, 1)));
    RST = r; in_valid = v; in_fun = b;
    model(r, v, b);
    if (v && !r && !zmode) begin
      sp = (sp + 1) % 15;
      if (flips > 0) flips--;
    end
    armed = 1;
  endtask
  initial begin
    sp = $urandom_range(0, 14);
    flips = 0; zmode = 0; armed = 0;
    cyc(1, 0);
    cyc(1, 1);
    for (int k = 0; k < 60; k++) cyc(0, $urandom_range(0, 2) != 0);
    check("lock_bits", lock_at, 12);
    for (int k = 0; k < 40; k++) begin
      if (k == 10) flips = 1;
      cyc(0, 1);
    end
    flips = 3;
    for (int k = 0; k < 40; k++) cyc(0, 1);
    for (int k = 0; k < 30; k++) begin
      if (k % 6 == 0) flips = 1;
      cyc(0, 1);
    end
    cyc(1, 1);
    for (int k = 0; k < 40; k++) cyc(0, 1);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) flips = $urandom_range(1, 3);
      cyc(0, $urandom_range(0, 3) != 0);
    end
    cyc(1, 0);
    zmode = 1;
    for (int k = 0; k < 60; k++) cyc(0, $urandom_range(0, 4) != 0);
    zmode = 0;
    cyc(1, 0);
    for (int k = 0; k < 60; k++) cyc(0, k % 3 == 0);
    @(negedge CLK_50MHZ);
    check_all();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
